// File: rtl/atom_select_if.sv
`default_nettype none
// ============================================================================
//  Module      : atom_select_if
//  Description : Control, correlation-stream and index-register-file signals
//                of the OMP atom-selection stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface atom_select_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 6,
  parameter int ADDR_W = 4
);
  // Control
  logic                     start;
  logic [ADDR_W-1:0]        iter;
  logic                     clear_mask;
  // Correlation stream
  logic                     corr_valid;
  logic signed [DATA_W-1:0] corr_data;
  logic                     corr_ready;
  // Index register file write port
  logic                     wr_en;
  logic [ADDR_W-1:0]        addr;
  logic [IDX_W-1:0]         D;
  // Completion / result
  logic                     done;
  logic                     none_found;
  logic [IDX_W-1:0]         sel_idx;
  logic [DATA_W-1:0]        sel_mag;

  modport master (
    output start, iter, clear_mask, corr_valid, corr_data,
    input  corr_ready, wr_en, addr, D, done, none_found, sel_idx, sel_mag
  );

  modport slave (
    input  start, iter, clear_mask, corr_valid, corr_data,
    output corr_ready, wr_en, addr, D, done, none_found, sel_idx, sel_mag
  );
endinterface
`default_nettype wire

// File: rtl/atom_select.sv
`default_nettype none
// ============================================================================
//  Module      : atom_select
//  Description : Scans one iteration's correlation stream, picks the
//                largest-magnitude atom not yet selected, writes its index
//                into the index register file and marks it in a persistent
//                selected-atom bitmap.
//  Revision    : 1.0  initial release
// ============================================================================
module atom_select #(
  parameter int DATA_W = 16,
  parameter int N_ATOM = 64,
  parameter int IDX_W  = 6,
  parameter int ADDR_W = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  atom_select_if.slave   bus
);

  localparam logic [IDX_W-1:0]  c_LAST_CNT = IDX_W'(N_ATOM - 1);
  localparam logic [IDX_W-1:0]  c_CNT_ONE  = IDX_W'(1);
  localparam logic [DATA_W-1:0] c_MAG_ONE  = DATA_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_WRITE = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [N_ATOM-1:0]   r_bitmap;
  logic [IDX_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_best_idx;
  logic [DATA_W-1:0]   r_best_mag;
  logic                r_best_vld;
  logic [ADDR_W-1:0]   r_iter;

  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [IDX_W-1:0]    r_D;
  logic                r_done;
  logic                r_none_found;
  logic [IDX_W-1:0]    r_sel_idx;
  logic [DATA_W-1:0]   r_sel_mag;

  logic                w_accept;
  logic [DATA_W-1:0]   w_mag;
  logic                w_elig;
  logic                w_take;
  logic                w_last;
  logic                w_best_vld_nxt;
  logic [IDX_W-1:0]    w_best_idx_nxt;

  // Beat qualification and running-maximum comparison for the current sample.
  // The magnitude is taken as an unsigned value so the most negative input
  // maps to 2^(DATA_W-1) without overflowing.
  always_comb begin
    w_accept       = (r_state == S_SCAN) && bus.corr_valid;
    w_mag          = bus.corr_data[DATA_W-1] ? (~bus.corr_data + c_MAG_ONE)
                                             : bus.corr_data;
    w_elig         = ~r_bitmap[r_cnt];
    w_take         = w_accept && w_elig && (!r_best_vld || (w_mag > r_best_mag));
    w_last         = w_accept && (r_cnt == c_LAST_CNT);
    w_best_vld_nxt = r_best_vld | w_take;
    w_best_idx_nxt = w_take ? r_cnt : r_best_idx;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> SCAN on start, SCAN -> WRITE after the last
  // beat, then one cycle each in WRITE and FIN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_last)    w_state_nxt = S_WRITE;
      S_WRITE:                w_state_nxt = S_FIN;
      S_FIN:                  w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: scan tracking, bitmap, write-port and result registers. The
  // write port is loaded on the last beat so wr_en/addr/D are valid for the
  // whole WRITE cycle and addr/D keep the last written values afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitmap     <= '0;
      r_cnt        <= '0;
      r_best_idx   <= '0;
      r_best_mag   <= '0;
      r_best_vld   <= 1'b0;
      r_iter       <= '0;
      r_wr_en      <= 1'b0;
      r_addr       <= '0;
      r_D          <= '0;
      r_done       <= 1'b0;
      r_none_found <= 1'b0;
      r_sel_idx    <= '0;
      r_sel_mag    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Clearing and starting on the same edge gives the new scan an
          // empty mask, since the scan only reads the bitmap from SCAN on.
          if (bus.clear_mask) begin
            r_bitmap <= '0;
          end
          if (bus.start) begin
            r_iter     <= bus.iter;
            r_cnt      <= '0;
            r_best_vld <= 1'b0;
            r_best_mag <= '0;
          end
        end
        S_SCAN: begin
          if (w_accept) begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
          if (w_take) begin
            r_best_idx <= r_cnt;
            r_best_mag <= w_mag;
            r_best_vld <= 1'b1;
          end
          if (w_last) begin
            r_wr_en <= w_best_vld_nxt;
            if (w_best_vld_nxt) begin
              r_addr <= r_iter;
              r_D    <= w_best_idx_nxt;
            end
          end
        end
        S_WRITE: begin
          r_wr_en <= 1'b0;
          if (r_best_vld) begin
            r_bitmap[r_best_idx] <= 1'b1;
          end
          r_done       <= 1'b1;
          r_none_found <= ~r_best_vld;
          r_sel_idx    <= r_best_vld ? r_best_idx : '0;
          r_sel_mag    <= r_best_vld ? r_best_mag : '0;
        end
        S_FIN: begin
          r_done       <= 1'b0;
          r_none_found <= 1'b0;
        end
        default: begin
          r_wr_en <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.corr_ready = (r_state == S_SCAN);
  assign bus.wr_en      = r_wr_en;
  assign bus.addr       = r_addr;
  assign bus.D          = r_D;
  assign bus.done       = r_done;
  assign bus.none_found = r_none_found;
  assign bus.sel_idx    = r_sel_idx;
  assign bus.sel_mag    = r_sel_mag;

endmodule
`default_nettype wire

// File: tb/tb_atom_select.sv
`default_nettype none
// ============================================================================
//  Module      : tb_atom_select
//  Description : Self-checking bench for atom_select with a behavioural
//                selection model (masked arg-max of |x|, lowest index wins).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_atom_select;

  localparam int DATA_W = 16;
  localparam int N_ATOM = 64;
  localparam int IDX_W  = 6;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  atom_select_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) ifc ();

  atom_select #(
    .DATA_W(DATA_W), .N_ATOM(N_ATOM), .IDX_W(IDX_W), .ADDR_W(ADDR_W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state
  bit                    m_mask [N_ATOM];
  int                    exp_addr = 0;
  int                    exp_D    = 0;
  logic signed [15:0]    dat [N_ATOM];

  function automatic int magof(input logic signed [15:0] x);
    int v;
    v = int'(x);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N_ATOM; k++) m_mask[k] = 1'b0;
  endtask

  task automatic fill_small();
    for (int k = 0; k < N_ATOM; k++) dat[k] = 16'(int'($urandom_range(200)) - 100);
  endtask

  // One full scan: start, stream (optional gaps, mid-scan start/clear
  // injection, optional reset abort), then check write, done and hold.
  task automatic run_scan(input int it, input bit cl, input int gap,
                          input int inject_at, input int abort_at);
    int  i, cyc, best, bm;
    bit  v;
    if (cl) model_clear();
    @(negedge clk);
    checks++;
    if (ifc.corr_ready !== 1'b0) begin
      failures++; $display("FAIL idle_ready: got %0b want 0", ifc.corr_ready);
    end
    ifc.start = 1'b1; ifc.iter = 4'(it); ifc.clear_mask = cl;
    @(negedge clk);
    ifc.start = 1'b0; ifc.clear_mask = 1'b0;
    i = 0; cyc = 0;
    while (i < N_ATOM) begin
      if (i == abort_at) begin
        ifc.corr_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({ifc.corr_ready, ifc.wr_en, ifc.addr, ifc.D, ifc.done, ifc.none_found,
             ifc.sel_idx, ifc.sel_mag} !== '0) begin
          failures++;
          $display("FAIL abort_outputs: got rdy=%0b wr=%0b addr=%0d D=%0d done=%0b nf=%0b idx=%0d mag=%0d want all 0",
                   ifc.corr_ready, ifc.wr_en, ifc.addr, ifc.D, ifc.done, ifc.none_found,
                   ifc.sel_idx, ifc.sel_mag);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        exp_addr = 0; exp_D = 0;
        return;
      end
      v = (gap == 0) || ($urandom_range(99) >= gap);
      checks++;
      if (ifc.corr_ready !== 1'b1) begin
        failures++; $display("FAIL scan_ready: beat %0d got %0b want 1", i, ifc.corr_ready);
      end
      ifc.corr_valid = v;
      ifc.corr_data  = v ? dat[i] : 16'($urandom);
      if (i == inject_at) begin
        ifc.start = 1'b1; ifc.iter = 4'(~it); ifc.clear_mask = 1'b1;
      end
      @(negedge clk);
      ifc.start = 1'b0; ifc.clear_mask = 1'b0;
      if (v) i++;
      cyc++;
      if (cyc > 1000) begin
        failures++; $display("FAIL scan_timeout: beats %0d want %0d", i, N_ATOM);
        ifc.corr_valid = 1'b0;
        return;
      end
    end
    ifc.corr_valid = 1'b0;

    // Reference: eligible atom with the strictly largest magnitude, lowest index first.
    best = -1; bm = 0;
    for (int k = 0; k < N_ATOM; k++) begin
      if (!m_mask[k] && (best < 0 || magof(dat[k]) > bm)) begin
        best = k; bm = magof(dat[k]);
      end
    end
    if (best >= 0) begin exp_addr = it; exp_D = best; end

    // Cycle t+1: write strobe
    checks++;
    if (ifc.corr_ready !== 1'b0 || ifc.wr_en !== (best >= 0) ||
        ifc.addr !== 4'(exp_addr) || ifc.D !== 6'(exp_D)) begin
      failures++;
      $display("FAIL write: got rdy=%0b wr=%0b addr=%0d D=%0d want rdy=0 wr=%0b addr=%0d D=%0d",
               ifc.corr_ready, ifc.wr_en, ifc.addr, ifc.D, best >= 0, exp_addr, exp_D);
    end
    @(negedge clk);
    // Cycle t+2: done
    checks++;
    if (ifc.done !== 1'b1 || ifc.wr_en !== 1'b0 || ifc.none_found !== (best < 0) ||
        ifc.sel_idx !== 6'((best < 0) ? 0 : best) || ifc.sel_mag !== 16'(bm)) begin
      failures++;
      $display("FAIL done: got done=%0b wr=%0b nf=%0b idx=%0d mag=%0d want done=1 wr=0 nf=%0b idx=%0d mag=%0d",
               ifc.done, ifc.wr_en, ifc.none_found, ifc.sel_idx, ifc.sel_mag,
               best < 0, (best < 0) ? 0 : best, bm);
    end
    if (best >= 0) m_mask[best] = 1'b1;
    @(negedge clk);
    // Cycle t+3: results held, pulses gone
    checks++;
    if (ifc.done !== 1'b0 || ifc.wr_en !== 1'b0 || ifc.addr !== 4'(exp_addr) ||
        ifc.D !== 6'(exp_D) || ifc.sel_idx !== 6'((best < 0) ? 0 : best) ||
        ifc.sel_mag !== 16'(bm)) begin
      failures++;
      $display("FAIL hold: got done=%0b wr=%0b addr=%0d D=%0d idx=%0d mag=%0d want done=0 wr=0 addr=%0d D=%0d idx=%0d mag=%0d",
               ifc.done, ifc.wr_en, ifc.addr, ifc.D, ifc.sel_idx, ifc.sel_mag,
               exp_addr, exp_D, (best < 0) ? 0 : best, bm);
    end
  endtask

  task automatic test_reset();
    ifc.start = 0; ifc.iter = '0; ifc.clear_mask = 0; ifc.corr_valid = 0; ifc.corr_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifc.corr_ready, ifc.wr_en, ifc.addr, ifc.D, ifc.done, ifc.none_found,
         ifc.sel_idx, ifc.sel_mag} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%0b wr=%0b addr=%0d D=%0d done=%0b nf=%0b idx=%0d mag=%0d want all 0",
               ifc.corr_ready, ifc.wr_en, ifc.addr, ifc.D, ifc.done, ifc.none_found,
               ifc.sel_idx, ifc.sel_mag);
    end
    rst = 1'b0;
    model_clear();
    exp_addr = 0; exp_D = 0;
  endtask

  task automatic test_basic();
    @(negedge clk); ifc.clear_mask = 1'b1;
    @(negedge clk); ifc.clear_mask = 1'b0;
    model_clear();
    fill_small();
    dat[17] = -16'sd300;
    run_scan(0, 1'b0, 0, -1, -1);
    checks++;
    if (ifc.D !== 6'd17 || ifc.sel_mag !== 16'd300) begin
      failures++; $display("FAIL basic_pick: got D=%0d mag=%0d want D=17 mag=300", ifc.D, ifc.sel_mag);
    end
  endtask

  task automatic test_exclusion();
    dat[40] = 16'sd250;
    run_scan(1, 1'b0, 0, -1, -1);
    checks++;
    if (ifc.D !== 6'd40 || ifc.addr !== 4'd1) begin
      failures++; $display("FAIL exclude_pick: got D=%0d addr=%0d want D=40 addr=1", ifc.D, ifc.addr);
    end
    dat[17] = 16'sd1000;
    run_scan(2, 1'b0, 0, -1, -1);
    checks++;
    if (ifc.D === 6'd17) begin
      failures++; $display("FAIL exclude_again: got D=%0d want not 17", ifc.D);
    end
  endtask

  task automatic test_tie_extreme();
    for (int k = 0; k < N_ATOM; k++) dat[k] = '0;
    dat[5] = -16'sd32768; dat[9] = -16'sd32768;
    run_scan(3, 1'b1, 0, -1, -1);
    checks++;
    if (ifc.D !== 6'd5 || ifc.sel_mag !== 16'h8000) begin
      failures++; $display("FAIL tie_pick: got D=%0d mag=%0d want D=5 mag=32768", ifc.D, ifc.sel_mag);
    end
  endtask

  task automatic test_backpressure();
    fill_small();
    dat[17] = -16'sd300;
    run_scan(4, 1'b1, 50, -1, -1);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N_ATOM; k++) dat[k] = 16'($urandom);
      run_scan(int'($urandom_range(15)), 1'b0, 50, -1, -1);
    end
  endtask

  task automatic test_all_excluded();
    for (int s = 0; s < N_ATOM; s++) begin
      for (int k = 0; k < N_ATOM; k++) dat[k] = 16'($urandom);
      run_scan(s % 16, (s == 0), (s % 3 == 0) ? 30 : 0, -1, -1);
    end
    run_scan(7, 1'b0, 0, -1, -1);
    checks++;
    if (ifc.none_found !== 1'b0 || ifc.sel_idx !== 6'd0 || ifc.sel_mag !== 16'd0) begin
      failures++;
      $display("FAIL none_result: got nf=%0b idx=%0d mag=%0d want nf=0(after pulse) idx=0 mag=0",
               ifc.none_found, ifc.sel_idx, ifc.sel_mag);
    end
  endtask

  task automatic test_reset_ignores();
    // Mask is full here: an ignored mid-scan clear must still give none_found.
    for (int k = 0; k < N_ATOM; k++) dat[k] = 16'($urandom);
    run_scan(9, 1'b0, 0, 10, -1);
    // Abort at beat 30 with a very large candidate early on.
    dat[17] = 16'sd1000;
    run_scan(10, 1'b0, 0, -1, 30);
    // Mask empty again: atom 17 is selectable.
    fill_small();
    dat[17] = 16'sd1000;
    run_scan(11, 1'b0, 0, -1, -1);
    checks++;
    if (ifc.D !== 6'd17 || ifc.addr !== 4'd11) begin
      failures++; $display("FAIL post_reset_pick: got D=%0d addr=%0d want D=17 addr=11", ifc.D, ifc.addr);
    end
    // Ignored mid-scan start/clear with a partially filled mask.
    fill_small();
    run_scan(12, 1'b0, 40, 20, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exclusion();
    test_tie_extreme();
    test_backpressure();
    test_all_excluded();
    test_reset_ignores();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/atom_select.md
Name: atom_select

Overview:
- Per-iteration atom-selection stage of the OMP processor, directly upstream of the index register file.
- Consumes the stream of N_ATOM correlation values for one iteration and finds the atom with the largest magnitude, skipping atoms already chosen in earlier iterations.
- Writes the winning atom index into the index register file at the current iteration's address.
- Keeps a selected-atom bitmap across iterations until explicitly cleared.

Parameters:
- DATA_W, 16, width of signed two's-complement correlation samples
- N_ATOM, 64, number of atoms (correlation samples) per iteration
- IDX_W, 6, atom index width; must satisfy 2^IDX_W >= N_ATOM
- ADDR_W, 4, index register file address width (iteration number)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a scan when FSM is IDLE
- iter  in  ADDR_W  iteration number, latched on accepted start; used as write address
- clear_mask  in  1  clears the selected-atom bitmap; honoured only in IDLE
- corr_valid  in  1  correlation sample valid
- corr_data  in  DATA_W  signed correlation sample; arrives in atom order 0..N_ATOM-1
- corr_ready  out  1  high while FSM is in SCAN
- wr_en  out  1  index register file write strobe
- addr  out  ADDR_W  index register file address
- D  out  IDX_W  index register file write data (selected atom index)
- done  out  1  one-cycle completion pulse
- none_found  out  1  valid with done; 1 = every atom was already excluded, so no write occurred
- sel_idx  out  IDX_W  winning index, held from done until the next accepted start
- sel_mag  out  DATA_W  unsigned magnitude of the winner, held the same way

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - Bitmap, counter, best_idx, best_mag and best_vld are cleared.
  - All outputs are 0: corr_ready, wr_en, addr, D, done, none_found, sel_idx, sel_mag.
- FSM states: IDLE, SCAN, WRITE, FIN.
- IDLE:
  - start=1 latches iter, clears counter, best_vld and best_mag, then moves to SCAN.
  - clear_mask=1 zeroes the bitmap. If start and clear_mask are both high, clear takes effect first, so the new scan sees an empty mask.
- SCAN:
  - corr_ready=1. A beat is accepted when corr_valid && corr_ready. corr_valid low stalls with no state change.
  - Magnitude: mag = corr_data<0 ? -corr_data : corr_data, computed as an unsigned DATA_W-bit value. The most negative input -2^(DATA_W-1) gives 2^(DATA_W-1) exactly, with no overflow.
  - The beat is eligible if bitmap[counter]==0.
  - Best-value update on an eligible beat when best_vld==0 or mag > best_mag (strict): best_idx=counter, best_mag=mag, best_vld=1.
  - Ties keep the lower index. A zero magnitude is still selectable if it is the first eligible beat.
  - The counter increments per accepted beat.
  - The beat with counter==N_ATOM-1 is the last one: next state is WRITE, and corr_ready drops the following cycle.
- WRITE (one cycle):
  - If best_vld: wr_en=1, addr=latched iter, D=best_idx, and bitmap[best_idx] is set at the end of the cycle.
  - If !best_vld: wr_en=0.
  - Next state is FIN.
- FIN (one cycle):
  - done=1 and none_found=!best_vld.
  - sel_idx/sel_mag take best_idx/best_mag (both 0 if none found).
  - Next state is IDLE.
- Latency: last accepted beat at cycle t gives wr_en at t+1 and done at t+2. A start at t+3 is accepted.
- Outside WRITE, wr_en=0 and addr/D hold their last values.
- Ignored inputs:
  - start outside IDLE has no effect.
  - clear_mask outside IDLE has no effect; the bitmap persists.
  - corr_valid outside SCAN is ignored.
- Reset mid-scan aborts immediately: no write, no done, bitmap cleared.

Test Plan:
- Basic select: clear_mask, then start iter=0, stream 0..63 with data[17]=-300 and all others within ±100 -> wr_en one cycle with addr=0, D=17; done at t+2 with sel_mag=300, none_found=0.
- Exclusion: after the above, start iter=1 with the same stream and data[40]=250 -> D=40, addr=1 (atom 17 skipped); a third scan with data[17]=1000 still never picks 17.
- Tie/extreme: data[5]=data[9]=-32768 and all others 0 -> D=5, sel_mag=32768.
- Backpressure: random corr_valid gaps (about 50% duty) on the basic-select data -> identical result; corr_ready high only during SCAN; no beat lost.
- All excluded: N_ATOM scans without clear (one atom added per scan), then one more scan -> wr_en stays 0, done=1, none_found=1, sel_idx=0.
- Reset/ignores: a start pulse during SCAN is ignored; clear_mask during SCAN leaves the bitmap intact; rst asserted at beat 30 -> all outputs 0, no wr_en, bitmap empty (next scan can select a previously excluded atom).
